flash_arbiter: RTL and testbench

FLASH_ARBITER -- requirements
Module: flash_arbiter

---
 rtl/flash_arbiter.sv | 165 ++++++++++++++++
 tb/tb_flash_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_arbiter.sv
// -----------------------------------------------------------------------------
// flash_arbiter
//
// Two-port, read-only arbiter in front of a parallel NOR flash. Port 0 is the
// video fetch path, port 1 the game logic path. Each transaction:
//   IDLE   -> pick a winner (round-robin on ties), register its address onto
//             MemAdr, assert FlashCS/MemOE, load the wait counter.
//   ACCESS -> count WAIT_CYCLES edges, then latch MemDB into rdata and raise
//             the winner's ack; release FlashCS/MemOE on that same edge.
//   ACK    -> one cycle with exactly one ack high, then back to IDLE.
// With WAIT_CYCLES = W, a request sampled at edge E0 is acked from E0+W to
// E0+W+1 and the earliest following grant is at E0+W+2.
//
// Parameters
//   WAIT_CYCLES  clk cycles address/OE are held before MemDB is sampled (1..15)
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   req0/req1      read request, port 0 / port 1
//   addr0/addr1    word address [23:1], stable while the matching req is high
//   ack0/ack1      one-cycle read-complete strobe
//   rdata[15:0]    read word, valid while ack0 or ack1 is high, held otherwise
//   busy           high whenever the controller is not IDLE
//   MemAdr[23:1]   flash word address
//   MemDB[15:0]    flash data bus (input)
//   MemOE          flash output enable, active low
//   MemWR          flash write enable, active low, tied inactive
//   FlashCS        flash chip select, active low
//   FlashRp        flash reset/power-down, active low; released one edge after
//                  reset deasserts
// -----------------------------------------------------------------------------
module flash_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [23:1] addr0,
  input  logic [23:1] addr1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [23:1] MemAdr,
  input  logic [15:0] MemDB,
  output logic        MemOE,
  output logic        MemWR,
  output logic        FlashCS,
  output logic        FlashRp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t     state;
  logic [3:0] waitCnt;
  logic       lastGrant;   // port granted most recently (0 or 1)
  logic       curPort;     // port owning the transaction in flight

  logic       anyReq;
  logic       grantPort;
  logic [23:1] grantAddr;

  // Read-only controller: the write strobe never asserts.
  assign MemWR = 1'b1;

  // Winner selection. A lone requester always wins; on a tie the port that
  // was not granted last time wins.
  always_comb begin
    anyReq    = req0 | req1;
    grantPort = 1'b0;
    if (req0 && req1) begin
      grantPort = ~lastGrant;
    end else begin
      grantPort = req1;
    end
    grantAddr = grantPort ? addr1 : addr0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      waitCnt   <= 4'd0;
      lastGrant <= 1'b1;   // makes port 0 win the first tie
      curPort   <= 1'b0;
      MemAdr    <= '0;
      rdata     <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      busy      <= 1'b0;
      FlashCS   <= 1'b1;
      MemOE     <= 1'b1;
      FlashRp   <= 1'b0;
    end else begin
      // Flash leaves reset/power-down on the first edge after rst releases.
      FlashRp <= 1'b1;

      case (state)
        IDLE: begin
          if (anyReq) begin
            state     <= ACCESS;
            curPort   <= grantPort;
            lastGrant <= grantPort;
            MemAdr    <= grantAddr;
            FlashCS   <= 1'b0;
            MemOE     <= 1'b0;
            waitCnt   <= WAIT_LOAD;
            busy      <= 1'b1;
          end
        end

        ACCESS: begin
          // The edge that would take the counter from 1 to 0 is the sample edge.
          if (waitCnt <= 4'd1) begin
            waitCnt <= 4'd0;
            rdata   <= MemDB;
            ack0    <= ~curPort;
            ack1    <= curPort;
            FlashCS <= 1'b1;
            MemOE   <= 1'b1;
            state   <= ACK;
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end

        ACK: begin
          // Requests are ignored here; a req still high is seen again in IDLE.
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          busy    <= 1'b0;
          FlashCS <= 1'b1;
          MemOE   <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  ackExclusive: assert property (@(posedge clk) disable iff (!rst)
    !(ack0 && ack1));

  ackOneCycle: assert property (@(posedge clk) disable iff (!rst)
    (state == ACK) |=> (state == IDLE));

  adrHeldInAccess: assert property (@(posedge clk) disable iff (!rst)
    (state == ACCESS) |=> $stable(MemAdr));
`endif

endmodule

// File: tb/tb_flash_arbiter.sv
// -----------------------------------------------------------------------------
// tb_flash_arbiter
//
// Directed bench for flash_arbiter. A WAIT_CYCLES=2 instance runs a table of
// per-cycle vectors plus hand-written sequences for fairness and reset abort;
// a WAIT_CYCLES=5 instance checks the longer latency and busy window. The flash
// model returns MemAdr[16:1] 18 ns after any address change.
// -----------------------------------------------------------------------------
module tb_flash_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic [23:1] addr0, addr1;
  logic        ack0, ack1, busy;
  logic [15:0] rdata, memDB;
  logic [23:1] memAdr;
  logic        memOE, memWR, flashCS, flashRp;

  logic        req5;
  logic [23:1] addr5;
  logic        ack5a, ack5b, busy5;
  logic [15:0] rdata5, memDB5;
  logic [23:1] memAdr5;
  logic        memOE5, memWR5, flashCS5, flashRp5;

  int nCmp;
  int nFail;

  flash_arbiter #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .MemAdr(memAdr), .MemDB(memDB), .MemOE(memOE), .MemWR(memWR),
    .FlashCS(flashCS), .FlashRp(flashRp)
  );

  flash_arbiter #(.WAIT_CYCLES(5)) dut5 (
    .clk(clk), .rst(rst),
    .req0(req5), .req1(1'b0), .addr0(addr5), .addr1(23'h0),
    .ack0(ack5a), .ack1(ack5b), .rdata(rdata5), .busy(busy5),
    .MemAdr(memAdr5), .MemDB(memDB5), .MemOE(memOE5), .MemWR(memWR5),
    .FlashCS(flashCS5), .FlashRp(flashRp5)
  );

  // Flash model
  always @(memAdr)  memDB  <= #18 memAdr[16:1];
  always @(memAdr5) memDB5 <= #18 memAdr5[16:1];

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        r0, r1;
    logic [23:1] a0, a1;
    logic        eAck0, eAck1, eBusy, eCs, eOe;
    logic [15:0] eRdata;
    logic [23:1] eAdr;
  } vec_t;

  vec_t vecs [0:19];

  function automatic vec_t mk(input logic r0, input logic r1,
                              input logic [23:1] a0, input logic [23:1] a1,
                              input logic ea0, input logic ea1, input logic eb,
                              input logic ecs, input logic eoe,
                              input logic [15:0] erd, input logic [23:1] eadr);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.a0 = a0; v.a1 = a1;
    v.eAck0 = ea0; v.eAck1 = ea1; v.eBusy = eb; v.eCs = ecs; v.eOe = eoe;
    v.eRdata = erd; v.eAdr = eadr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic runVecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      req0  = vecs[i].r0;
      req1  = vecs[i].r1;
      addr0 = vecs[i].a0;
      addr1 = vecs[i].a1;
      tick();
      chk($sformatf("v%0d.ack0", i),    32'(ack0),    32'(vecs[i].eAck0));
      chk($sformatf("v%0d.ack1", i),    32'(ack1),    32'(vecs[i].eAck1));
      chk($sformatf("v%0d.busy", i),    32'(busy),    32'(vecs[i].eBusy));
      chk($sformatf("v%0d.FlashCS", i), 32'(flashCS), 32'(vecs[i].eCs));
      chk($sformatf("v%0d.MemOE", i),   32'(memOE),   32'(vecs[i].eOe));
      chk($sformatf("v%0d.rdata", i),   32'(rdata),   32'(vecs[i].eRdata));
      chk($sformatf("v%0d.MemAdr", i),  32'(memAdr),  32'(vecs[i].eAdr));
      chk($sformatf("v%0d.MemWR", i),   32'(memWR),   32'd1);
      chk($sformatf("v%0d.FlashRp", i), 32'(flashRp), 32'd1);
    end
  endtask

  initial begin
    int nAck;
    bit done;
    nCmp = 0;
    nFail = 0;

    // Tie after reset: port 0 first, port 1 at E0+4.
    vecs[0]  = mk(1, 1, 23'h000123, 23'h000456, 0, 0, 1, 0, 0, 16'h0000, 23'h000123);
    vecs[1]  = mk(1, 1, 23'h000123, 23'h000456, 0, 0, 1, 0, 0, 16'h0000, 23'h000123);
    vecs[2]  = mk(1, 1, 23'h000123, 23'h000456, 1, 0, 1, 1, 1, 16'h0123, 23'h000123);
    vecs[3]  = mk(0, 1, 23'h000123, 23'h000456, 0, 0, 0, 1, 1, 16'h0123, 23'h000123);
    vecs[4]  = mk(0, 1, 23'h000123, 23'h000456, 0, 0, 1, 0, 0, 16'h0123, 23'h000456);
    vecs[5]  = mk(0, 1, 23'h000123, 23'h000456, 0, 0, 1, 0, 0, 16'h0123, 23'h000456);
    vecs[6]  = mk(0, 1, 23'h000123, 23'h000456, 0, 1, 1, 1, 1, 16'h0456, 23'h000456);
    vecs[7]  = mk(0, 0, 23'h000123, 23'h000456, 0, 0, 0, 1, 1, 16'h0456, 23'h000456);
    // Single port-0 read with a req1 pulse during ACCESS, then port-1 reads
    // with req1 left high through ACK (re-granted only once IDLE is reached).
    vecs[8]  = mk(1, 0, 23'h000123, 23'h12ABCD, 0, 0, 1, 0, 0, 16'h0456, 23'h000123);
    vecs[9]  = mk(1, 1, 23'h000123, 23'h12ABCD, 0, 0, 1, 0, 0, 16'h0456, 23'h000123);
    vecs[10] = mk(1, 0, 23'h000123, 23'h12ABCD, 1, 0, 1, 1, 1, 16'h0123, 23'h000123);
    vecs[11] = mk(0, 0, 23'h000123, 23'h12ABCD, 0, 0, 0, 1, 1, 16'h0123, 23'h000123);
    vecs[12] = mk(0, 1, 23'h000123, 23'h12ABCD, 0, 0, 1, 0, 0, 16'h0123, 23'h12ABCD);
    vecs[13] = mk(0, 1, 23'h000123, 23'h12ABCD, 0, 0, 1, 0, 0, 16'h0123, 23'h12ABCD);
    vecs[14] = mk(0, 1, 23'h000123, 23'h12ABCD, 0, 1, 1, 1, 1, 16'hABCD, 23'h12ABCD);
    vecs[15] = mk(0, 1, 23'h000123, 23'h12ABCD, 0, 0, 0, 1, 1, 16'hABCD, 23'h12ABCD);
    vecs[16] = mk(0, 1, 23'h000123, 23'h12ABCD, 0, 0, 1, 0, 0, 16'hABCD, 23'h12ABCD);
    vecs[17] = mk(0, 0, 23'h000123, 23'h12ABCD, 0, 0, 1, 0, 0, 16'hABCD, 23'h12ABCD);
    vecs[18] = mk(0, 0, 23'h000123, 23'h12ABCD, 0, 1, 1, 1, 1, 16'hABCD, 23'h12ABCD);
    vecs[19] = mk(0, 0, 23'h000123, 23'h12ABCD, 0, 0, 0, 1, 1, 16'hABCD, 23'h12ABCD);

    rst   = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    addr0 = '0;
    addr1 = '0;
    req5  = 1'b0;
    addr5 = '0;

    // Asynchronous reset, checked before any clock edge.
    #2 rst = 1'b0;
    #2;
    chk("rst.busy",    32'(busy),    32'd0);
    chk("rst.ack0",    32'(ack0),    32'd0);
    chk("rst.ack1",    32'(ack1),    32'd0);
    chk("rst.FlashCS", 32'(flashCS), 32'd1);
    chk("rst.MemOE",   32'(memOE),   32'd1);
    chk("rst.MemWR",   32'(memWR),   32'd1);
    chk("rst.FlashRp", 32'(flashRp), 32'd0);
    chk("rst.MemAdr",  32'(memAdr),  32'd0);
    chk("rst.rdata",   32'(rdata),   32'd0);
    tick();
    chk("rstHeld.FlashRp", 32'(flashRp), 32'd0);
    rst = 1'b1;
    #1;
    chk("rstRel.FlashRp", 32'(flashRp), 32'd0);
    tick();
    chk("rstRel.FlashRpEdge", 32'(flashRp), 32'd1);
    chk("rstRel.busy",        32'(busy),    32'd0);

    runVecs(0, 7);

    // Fairness: both held, acks every 4 cycles alternating 0,1,0,1,0,1.
    req0  = 1'b1;
    req1  = 1'b1;
    addr0 = 23'h000123;
    addr1 = 23'h000456;
    nAck  = 0;
    done  = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      chk("fair.exclusive", 32'(ack0 & ack1), 32'd0);
      if (ack0 || ack1) begin
        chk($sformatf("fair.port%0d", nAck), 32'(ack1), 32'(nAck % 2));
        chk($sformatf("fair.rdata%0d", nAck), 32'(rdata),
            (nAck % 2 == 0) ? 32'h0123 : 32'h0456);
        chk($sformatf("fair.cycle%0d", nAck), 32'(c), 32'(3 + 4 * nAck));
        nAck++;
        if (nAck == 6) begin
          req0 = 1'b0;
          req1 = 1'b0;
          done = 1'b1;
          break;
        end
      end
    end
    chk("fair.ackCount", 32'(nAck), 32'd6);
    if (!done) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
    tick();
    chk("fair.idle", 32'(busy), 32'd0);

    runVecs(8, 19);

    // Reset one cycle after grant aborts the read.
    req0  = 1'b1;
    addr0 = 23'h000789;
    tick();
    chk("abort.granted", 32'(flashCS), 32'd0);
    req0 = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    chk("abort.FlashCS", 32'(flashCS), 32'd1);
    chk("abort.MemOE",   32'(memOE),   32'd1);
    chk("abort.ack0",    32'(ack0),    32'd0);
    chk("abort.rdata",   32'(rdata),   32'd0);
    chk("abort.busy",    32'(busy),    32'd0);
    chk("abort.FlashRp", 32'(flashRp), 32'd0);
    chk("abort.MemAdr",  32'(memAdr),  32'd0);
    tick();
    chk("abort.noAck", 32'(ack0 | ack1), 32'd0);
    rst = 1'b1;
    tick();
    chk("abort.FlashRp1", 32'(flashRp), 32'd1);
    chk("abort.stillIdle", 32'(busy | ack0 | ack1), 32'd0);
    req1  = 1'b1;
    addr1 = 23'h000456;
    tick();
    chk("abort.regrant",  32'(memAdr), 32'h000456);
    tick();
    chk("abort.waitAck",  32'(ack1), 32'd0);
    tick();
    chk("abort.ack1",  32'(ack1),  32'd1);
    chk("abort.ack0",  32'(ack0),  32'd0);
    chk("abort.rdata2", 32'(rdata), 32'h0456);
    req1 = 1'b0;
    tick();
    chk("abort.done", 32'(busy | ack1), 32'd0);

    // WAIT_CYCLES=5 instance: ack at E0+5, busy over E0..E0+6.
    req5  = 1'b1;
    addr5 = 23'h000321;
    for (int k = 0; k <= 7; k++) begin
      tick();
      chk($sformatf("w5.busy%0d", k), 32'(busy5), (k <= 5) ? 32'd1 : 32'd0);
      chk($sformatf("w5.ack%0d", k),  32'(ack5a), (k == 5) ? 32'd1 : 32'd0);
      chk($sformatf("w5.ack1_%0d", k), 32'(ack5b), 32'd0);
      if (k >= 5) begin
        chk($sformatf("w5.rdata%0d", k), 32'(rdata5), 32'h0321);
      end
      if (k == 5) req5 = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
